// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared constants and state encoding for the reorder-buffer control slice
package rob_pkg;

  localparam int ROB_ENTRIES = 8;
  localparam int ROB_PTR_W   = 3;
  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;

endpackage

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrapping pointer register with enable and synchronous clear
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  // Entry count is a power of two, so natural overflow provides the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - ROB allocate/commit/flush control; optional counters under ROB_COMMIT_STATS_EN
module rob_commit_ctrl
  import rob_pkg::*;
#(
  parameter int NUM_ENTRIES = rob_pkg::ROB_ENTRIES,
  parameter int PTR_W       = rob_pkg::ROB_PTR_W,
  parameter int XLEN        = rob_pkg::XLEN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  output logic [NUM_ENTRIES-1:0]          alloc_sel,
  output logic [PTR_W-1:0]                alloc_tag,
  input  logic [NUM_ENTRIES-1:0]          entry_wen,
  input  logic [NUM_ENTRIES*REG_ADDR_W-1:0] entry_dest,
  input  logic [NUM_ENTRIES*XLEN-1:0]     entry_val,
  output logic [PTR_W-1:0]                head,
  input  logic                            flush,
  output logic                            rf_we,
  output logic [REG_ADDR_W-1:0]           rf_waddr,
  output logic [XLEN-1:0]                 rf_wdata,
  output logic [PTR_W:0]                  count,
  output logic                            empty,
  output logic                            full
`ifdef ROB_COMMIT_STATS_EN
  ,
  output logic [31:0]                     commit_cnt,
  output logic [31:0]                     full_stall_cnt
`endif
);

  rob_state_e               state_q, state_d;
  logic [PTR_W-1:0]         tail;
  logic                     in_run;
  logic                     do_alloc;
  logic                     do_commit;
  logic                     head_wen;
  logic [REG_ADDR_W-1:0]    head_dest;
  logic [XLEN-1:0]          head_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush sampled in either state schedules exactly one FLUSH cycle after it.
  always_comb begin
    state_d = ST_RUN;
    if (flush) begin
      state_d = ST_FLUSH;
    end
  end

  assign in_run = (state_q == ST_RUN);
  assign empty  = (count == '0);
  assign full   = (count == (PTR_W+1)'(NUM_ENTRIES));

  assign issue_ready = in_run && !full && !flush;
  assign do_alloc    = issue_valid && issue_ready;
  assign alloc_tag   = tail;
  assign alloc_sel   = do_alloc ? (NUM_ENTRIES'(1) << tail) : '0;

  // Only the head entry's strobe and payload matter; all other lanes are ignored.
  always_comb begin
    head_wen  = 1'b0;
    head_dest = '0;
    head_val  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (PTR_W'(i) == head) begin
        head_wen  = entry_wen[i];
        head_dest = entry_dest[i*REG_ADDR_W +: REG_ADDR_W];
        head_val  = entry_val[i*XLEN +: XLEN];
      end
    end
  end

  assign do_commit = in_run && !empty && head_wen && !flush;

  rob_ptr #(.W(PTR_W)) u_head_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (do_commit),
    .clr   (!in_run),
    .ptr   (head)
  );

  rob_ptr #(.W(PTR_W)) u_tail_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (do_alloc),
    .clr   (!in_run),
    .ptr   (tail)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !in_run) begin
      count <= '0;
    end else if (do_alloc && !do_commit) begin
      count <= count + (PTR_W+1)'(1);
    end else if (do_commit && !do_alloc) begin
      count <= count - (PTR_W+1)'(1);
    end
  end

  // x0 commits retire normally but never raise the write enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= do_commit && (head_dest != '0);
      if (do_commit) begin
        rf_waddr <= head_dest;
        rf_wdata <= head_val;
      end
    end
  end

`ifdef ROB_COMMIT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_cnt     <= '0;
      full_stall_cnt <= '0;
    end else begin
      if (do_commit && (commit_cnt != '1)) begin
        commit_cnt <= commit_cnt + 32'd1;
      end
      if (issue_valid && full && (full_stall_cnt != '1)) begin
        full_stall_cnt <= full_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - randomized and directed checks of rob_commit_ctrl against a reference model
module tb_rob_commit_ctrl;

  localparam int N  = 8;
  localparam int PW = 3;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic            issue_ready;
  logic [N-1:0]    alloc_sel;
  logic [PW-1:0]   alloc_tag;
  logic [N-1:0]    entry_wen;
  logic [N*5-1:0]  entry_dest;
  logic [N*XL-1:0] entry_val;
  logic [PW-1:0]   head;
  logic            flush;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XL-1:0]   rf_wdata;
  logic [PW:0]     count;
  logic            empty;
  logic            full;
`ifdef ROB_COMMIT_STATS_EN
  logic [31:0]     commit_cnt;
  logic [31:0]     full_stall_cnt;
`endif

  rob_commit_ctrl #(.NUM_ENTRIES(N), .PTR_W(PW), .XLEN(XL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .alloc_sel   (alloc_sel),
    .alloc_tag   (alloc_tag),
    .entry_wen   (entry_wen),
    .entry_dest  (entry_dest),
    .entry_val   (entry_val),
    .head        (head),
    .flush       (flush),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .count       (count),
    .empty       (empty),
    .full        (full)
`ifdef ROB_COMMIT_STATS_EN
    ,
    .commit_cnt     (commit_cnt),
    .full_stall_cnt (full_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: occupancy, pointers modulo N, pending flush, expected rf write.
  int          m_head, m_tail, m_cnt;
  bit          m_flushing;
  bit          m_rf_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          hold_data = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_cnt = 0; m_flushing = 0;
    m_rf_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  task automatic step(input bit iv, input logic [N-1:0] wen, input bit fl);
    bit          ready, alloc, commit;
    logic [4:0]  d;
    logic [31:0] v;
    logic [N-1:0] esel;
    @(negedge clk);
    issue_valid = iv;
    entry_wen   = wen;
    flush       = fl;
    if (!hold_data) begin
      for (int i = 0; i < N; i++) begin
        entry_dest[i*5 +: 5]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        entry_val[i*XL +: XL]  = $urandom;
      end
    end
    #1;
    ready  = !m_flushing && (m_cnt < N) && !fl;
    alloc  = iv && ready;
    commit = !m_flushing && (m_cnt > 0) && wen[m_head] && !fl;
    esel   = alloc ? (N'(1) << m_tail) : '0;
    chk("issue_ready", issue_ready, ready);
    chk("alloc_sel", alloc_sel, esel);
    if (alloc) chk("alloc_tag", alloc_tag, m_tail);
    chk("head", head, m_head);
    chk("count", count, m_cnt);
    chk("empty", empty, m_cnt == 0);
    chk("full", full, m_cnt == N);
    chk("rf_we", rf_we, m_rf_we);
    if (m_rf_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    d = entry_dest[m_head*5 +: 5];
    v = entry_val[m_head*XL +: XL];
    m_rf_we = commit && (d != 0);
    if (commit) begin m_waddr = d; m_wdata = v; end
    if (m_flushing) begin
      m_head = 0; m_tail = 0; m_cnt = 0;
    end else begin
      if (commit) begin m_head = (m_head + 1) % N; m_cnt--; end
      if (alloc)  begin m_tail = (m_tail + 1) % N; m_cnt++; end
    end
    m_flushing = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; issue_valid = 0; entry_wen = '0; flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 0; entry_wen = '0; flush = 0;
    entry_dest = '0; entry_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_head", head, 0);
    chk("rst_rf_we", rf_we, 0);
    rst_n = 1'b1;

    // Fill all entries; tags come out 0..7 through the model checks.
    for (int i = 0; i < N; i++) step(1, '0, 0);
    chk("fill_full", full, 1);
    chk("fill_ready", issue_ready, 0);
    chk("fill_no_sel", alloc_sel, 0);
    step(1, '0, 0);
    step(0, '0, 1);
    step(0, '0, 0);
    chk("clr_count", count, 0);

    // Ordered commit with fixed payloads.
    hold_data = 1;
    entry_dest = '0; entry_val = '0;
    entry_dest[0 +: 5] = 5'd5;  entry_val[0 +: 32]  = 32'hDEADBEEF;
    entry_dest[5 +: 5] = 5'd7;  entry_val[32 +: 32] = 32'h12345678;
    for (int i = 0; i < 3; i++) step(1, '0, 0);
    step(0, 8'b0000_0010, 0);
    chk("ooo_head", head, 0);
    chk("ooo_rf_we", rf_we, 0);
    step(0, 8'b0000_0011, 0);
    chk("c0_rf_we", rf_we, 1);
    chk("c0_waddr", rf_waddr, 5);
    chk("c0_wdata", rf_wdata, 32'hDEADBEEF);
    chk("c0_head", head, 1);
    chk("c0_count", count, 2);
    step(0, 8'b0000_0011, 0);
    chk("c1_waddr", rf_waddr, 7);
    chk("c1_head", head, 2);
    hold_data = 0;

    // Simultaneous issue and commit at count 3, wrapping pointers.
    for (int i = 0; i < 2; i++) step(1, '0, 0);
    for (int i = 0; i < 20; i++) step(1, '1, 0);
    chk("both_count", count, 3);
    chk("both_head", head, 6);

    hold_data = 1;
    entry_dest = '0;
    step(0, '1, 0);
    chk("x0_rf_we", rf_we, 0);
    chk("x0_head", head, 7);
    hold_data = 0;

    // Flush with concurrent issue and commit requests at count 5.
    for (int i = 0; i < 3; i++) step(1, '0, 0);
    chk("pre_flush_count", count, 5);
    step(1, '1, 1);
    chk("fl_rf_we", rf_we, 0);
    step(1, '1, 0);
    chk("fl_head", head, 0);
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_ready", issue_ready, 1);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      step($urandom_range(0, 9) < 6, N'($urandom), $urandom_range(0, 31) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Control block for the reorder buffer (ROB) array.
- Upstream side: allocates ROB entries to issuing instructions. Drives a one-hot `alloc_sel` into the entry array and returns the entry tag (tail pointer).
- Downstream side: watches each entry's `wen`/`dest`/`val` outputs, commits the head entry to the architectural register file in program order, then advances `head`.
- Owns the head/tail pointers, occupancy count, full/empty status and flush recovery.

Parameters:
- NUM_ENTRIES, 8, number of ROB entries; power of two, 2..16.
- PTR_W, 3, pointer width; equals log2(NUM_ENTRIES).
- XLEN, 32, data width of committed values.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- issue_valid  in  1  the decoder requests an entry this cycle.
- issue_ready  out  1  an entry can be allocated (ROB not full, not flushing).
- alloc_sel  out  NUM_ENTRIES  one-hot select to the entry array; bit[tail] is set when issue_valid && issue_ready.
- alloc_tag  out  PTR_W  tag of the entry allocated this cycle (equals tail).
- entry_wen  in  NUM_ENTRIES  per-entry commit strobe from the entry array.
- entry_dest  in  NUM_ENTRIES*5  packed per-entry destination register; entry i occupies [5i+4:5i].
- entry_val  in  NUM_ENTRIES*XLEN  packed per-entry result value.
- head  out  PTR_W  oldest uncommitted entry; broadcast to all entries.
- flush  in  1  mispredict/exception recovery request.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  5  registered register-file write address.
- rf_wdata  out  XLEN  registered register-file write data.
- count  out  PTR_W+1  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == NUM_ENTRIES.

Behaviour:
- Reset values: head=0, tail=0, count=0, rf_we=0, rf_waddr=0, rf_wdata=0, state=RUN. Resulting outputs: empty=1, full=0, issue_ready=1, alloc_sel=0.
- State machine has two states:
  - RUN: normal operation.
  - FLUSH: entered one cycle after flush is sampled high; lasts exactly one cycle, then returns to RUN.
- In FLUSH:
  - issue_ready=0 and alloc_sel=0.
  - head, tail and count are cleared to 0 at the end of the FLUSH cycle.
  - rf_we=0.
- A flush asserted while already in FLUSH keeps the block in FLUSH for one more cycle.
- Allocation:
  - An entry is allocated when issue_valid && issue_ready.
  - issue_ready = (state==RUN) && !full && !flush.
  - alloc_sel is combinational and is zero unless an entry is allocated.
  - tail increments by 1 and wraps modulo NUM_ENTRIES.
- Commit:
  - A commit occurs when state==RUN && !empty && entry_wen[head] && !flush.
  - On commit, the next cycle has rf_we=1, rf_waddr=entry_dest[head], rf_wdata=entry_val[head] (one-cycle latency).
  - head increments and wraps. At most one commit per cycle.
- Register x0: a commit with dest==0 still advances head, but rf_we stays 0.
- entry_wen bits for entries other than head are ignored, including a spurious entry_wen while empty.
- Count update:
  - allocate only: count+1.
  - commit only: count-1.
  - both in the same cycle: count unchanged, and both pointers advance.
- Full: an allocation and a commit cannot both complete when full, because issue_ready=0 while full. The slot freed by a commit is offered on the next cycle.
- Empty: no commit occurs. Allocating into an empty ROB makes empty=0 on the next cycle.
- Flush precedence: flush takes precedence over a same-cycle allocation and commit; neither occurs.
- Reset mid-operation: rst_n low in any state returns every register to its reset value on the next edge.

Optional Feature:
- Macro: ROB_COMMIT_STATS_EN.
- When defined, the block adds these output ports:
  - commit_cnt (32 bits): increments on every commit, including commits to x0; saturates at all-ones.
  - full_stall_cnt (32 bits): increments on every cycle with issue_valid && full; saturates at all-ones.
  - Both counters clear on reset only; flush does not clear them.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package `rob_pkg` holds:
  - ROB_ENTRIES, ROB_PTR_W, XLEN, REG_ADDR_W=5.
  - State encoding constants ST_RUN=0, ST_FLUSH=1.
- One natural sub-module: `rob_ptr`, a wrapping pointer register with enable and synchronous clear, instantiated once for head and once for tail.
- The rf write register, count logic and FSM stay in the top module.

Test Plan:
- Reset then 8 issues with no commits: alloc_tag sequence is 0..7. After the 8th issue, full=1 and issue_ready=0; a 9th issue_valid gets no alloc_sel.
- Allocate tags 0..2, pulse entry_wen[0] with dest=5 and val=0xDEADBEEF: the next cycle shows rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; head=1 and count=2.
- Hold entry_wen[1] high while head=0: no commit. Then entry_wen[0] fires: entries 0 and 1 commit in order on consecutive cycles.
- With count=3, issue and commit in the same cycle: count stays 3 and both head and tail advance. Drive 20 such cycles: pointers wrap past 7 to 0.
- Commit an entry with dest=0: head advances and rf_we stays 0.
- With count=5, assert flush together with issue_valid and entry_wen[head]: no alloc_sel and no rf_we. After the FLUSH cycle, head=tail=0, count=0, empty=1 and issue_ready=1.
